// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, opcodes and datapath select encodings for mc_controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_WB_LD    = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JAL      = 4'd9,
    S_HALT     = 4'd10
  } state_t;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_LOAD  = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_JAL   = 4'b1101;
  localparam logic [1:0] SRCB_RB   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM6 = 2'b10;
  localparam logic [1:0] SRCB_IMM9 = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MDR = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_ADD, OP_STORE, OP_LOAD, OP_BEQ, OP_JAL};
  endfunction
endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: combinational map from state, opcode and zero to control strobes and selects
module mc_output_decode
  import mc_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_zero,
  output logic       o_pc_en,
  output logic       o_ir_write,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_iord,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_aluop,
  output logic       o_regdst,
  output logic [1:0] o_memtoreg,
  output logic       o_pcsrc,
  output logic       o_illegal
);
  // per-state controls; anything a state does not name stays at zero
  always_comb begin
    o_pc_en     = 1'b0;
    o_ir_write  = 1'b0;
    o_mem_write = 1'b0;
    o_reg_write = 1'b0;
    o_iord      = 1'b0;
    o_alusrca   = 1'b0;
    o_alusrcb   = SRCB_RB;
    o_aluop     = ALU_ADD;
    o_regdst    = 1'b0;
    o_memtoreg  = MTR_ALU;
    o_pcsrc     = 1'b0;
    o_illegal   = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_ir_write = 1'b1;
        o_pc_en    = 1'b1;
        o_alusrcb  = SRCB_ONE;
      end
      S_DECODE: begin
        o_alusrcb = (i_opcode == OP_JAL) ? SRCB_IMM9 : SRCB_IMM6;
        o_illegal = !is_legal(i_opcode);
      end
      S_EXEC_R: o_alusrca = 1'b1;
      S_WB_R: o_reg_write = 1'b1;
      S_MEM_ADDR: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM6;
      end
      S_MEM_RD: o_iord = 1'b1;
      S_WB_LD: begin
        o_reg_write = 1'b1;
        o_regdst    = 1'b1;
        o_memtoreg  = MTR_MDR;
      end
      S_MEM_WR: begin
        o_iord      = 1'b1;
        o_mem_write = 1'b1;
      end
      S_BRANCH: begin
        o_alusrca = 1'b1;
        o_aluop   = ALU_SUB;
        o_pcsrc   = 1'b1;
        o_pc_en   = i_zero;
      end
      S_JAL: begin
        o_reg_write = 1'b1;
        o_regdst    = 1'b1;
        o_memtoreg  = MTR_PC;
        o_pcsrc     = 1'b1;
        o_pc_en     = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle CPU control FSM; define ILLEGAL_TRAP_EN to halt on illegal opcodes
module mc_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        carry,
  output logic        pc_en,
  output logic        ir_write,
  output logic        mem_write,
  output logic        reg_write,
  output logic        iord,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic        regdst,
  output logic [1:0]  memtoreg,
  output logic        pcsrc,
  output logic [3:0]  state,
  output logic        illegal
);
  state_t     r_state, w_next;
  logic       r_c, r_z;
  logic [3:0] w_op;
  logic [1:0] w_cz;
  logic       w_add_go;
  logic       w_pc_en, w_ir_write, w_mem_write, w_reg_write, w_illegal;
  logic       w_unused;
  assign w_op     = instr[15:12];
  assign w_cz     = instr[1:0];
  assign w_unused = ^instr[11:2];
  assign w_add_go = (w_cz == 2'b00) | ((w_cz == 2'b10) & r_c) | ((w_cz == 2'b01) & r_z);
  // state and flag registers; flags only capture the ALU result of an executed ADD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXEC_R) begin
        r_c <= carry;
        r_z <= zero;
      end
    end
  end
  // next-state selection
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_ADD:            w_next = w_add_go ? S_EXEC_R : S_FETCH;
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_BEQ:            w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           w_next = S_HALT;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R:   w_next = S_WB_R;
      S_MEM_ADDR: w_next = (w_op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = S_WB_LD;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end
  mc_output_decode u_dec (
    .i_state     (r_state),
    .i_opcode    (w_op),
    .i_zero      (zero),
    .o_pc_en     (w_pc_en),
    .o_ir_write  (w_ir_write),
    .o_mem_write (w_mem_write),
    .o_reg_write (w_reg_write),
    .o_iord      (iord),
    .o_alusrca   (alusrca),
    .o_alusrcb   (alusrcb),
    .o_aluop     (aluop),
    .o_regdst    (regdst),
    .o_memtoreg  (memtoreg),
    .o_pcsrc     (pcsrc),
    .o_illegal   (w_illegal)
  );
  assign pc_en     = w_pc_en & ~reset;
  assign ir_write  = w_ir_write & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign illegal   = w_illegal & ~reset;
  assign state     = r_state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed vector table plus reset/illegal sequences for mc_controller
module tb_mc_controller;
  logic        clk, reset, zero, carry;
  logic [15:0] instr;
  logic        pc_en, ir_write, mem_write, reg_write, iord, alusrca, regdst, pcsrc, illegal;
  logic [1:0]  alusrcb, aluop, memtoreg;
  logic [3:0]  state;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        zero;
    logic        carry;
    logic [18:0] exp;
  } vec_t;
  vec_t tbl[$];
  localparam logic [15:0] ADD0 = 16'h02a0, ADDC = 16'h02a2, ADDZ = 16'h02a1;
  localparam logic [15:0] LD = 16'ha281, ST = 16'h9c4c, BEQ = 16'hb744, JAL = 16'hd000, ILL = 16'hf000;

  mc_controller dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .carry(carry),
    .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst),
    .memtoreg(memtoreg), .pcsrc(pcsrc), .state(state), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected fields: state, {pc_en,ir_write,mem_write,reg_write}, iord, alusrca, alusrcb, aluop, regdst, memtoreg, pcsrc, illegal
  function automatic vec_t v(input logic rst, input logic [15:0] ins, input logic z, input logic c,
                             input logic [3:0] st, input logic [3:0] stb, input logic io, input logic sa,
                             input logic [1:0] sb, input logic [1:0] op, input logic rd, input logic [1:0] mt,
                             input logic pc, input logic il);
    vec_t r;
    r.rst = rst; r.instr = ins; r.zero = z; r.carry = c;
    r.exp = {st, stb, io, sa, sb, op, rd, mt, pc, il};
    return r;
  endfunction

  function automatic vec_t fetch(input logic [15:0] ins);
    return v(0, ins, 0, 0, 4'd0, 4'b1100, 0, 0, 2'b01, 2'b00, 0, 2'b00, 0, 0);
  endfunction

  function automatic vec_t dec(input logic [15:0] ins);
    return v(0, ins, 0, 0, 4'd1, 4'b0000, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0);
  endfunction

  task automatic step(input vec_t t, input string tag);
    logic [18:0] got;
    reset = t.rst; instr = t.instr; zero = t.zero; carry = t.carry;
    #1;
    got = {state, pc_en, ir_write, mem_write, reg_write, iord, alusrca, alusrcb, aluop, regdst, memtoreg, pcsrc, illegal};
    n_vec++;
    if (got !== t.exp) begin
      n_err++;
      $display("FAIL %s vec%0d: got %b expected %b", tag, n_vec, got, t.exp);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; instr = 16'h0; zero = 1'b0; carry = 1'b0;
    @(posedge clk);
    #2;
    tbl.push_back(v(1, ADD0, 0, 0, 4'd0, 4'b0000, 0, 0, 2'b01, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(fetch(ADD0));
    tbl.push_back(dec(ADD0));
    tbl.push_back(v(0, ADD0, 0, 1, 4'd2, 4'b0000, 0, 1, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, ADD0, 0, 0, 4'd3, 4'b0001, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(fetch(ADDC));
    tbl.push_back(dec(ADDC));
    tbl.push_back(v(0, ADDC, 0, 0, 4'd2, 4'b0000, 0, 1, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, ADDC, 0, 0, 4'd3, 4'b0001, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(fetch(ADDC));
    tbl.push_back(dec(ADDC));
    tbl.push_back(fetch(ADDZ));
    tbl.push_back(dec(ADDZ));
    tbl.push_back(fetch(LD));
    tbl.push_back(dec(LD));
    tbl.push_back(v(0, LD, 0, 0, 4'd4, 4'b0000, 0, 1, 2'b10, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, LD, 0, 0, 4'd5, 4'b0000, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, LD, 0, 0, 4'd6, 4'b0001, 0, 0, 2'b00, 2'b00, 1, 2'b01, 0, 0));
    tbl.push_back(fetch(ST));
    tbl.push_back(dec(ST));
    tbl.push_back(v(0, ST, 0, 0, 4'd4, 4'b0000, 0, 1, 2'b10, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, ST, 0, 0, 4'd7, 4'b0010, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(fetch(BEQ));
    tbl.push_back(dec(BEQ));
    tbl.push_back(v(0, BEQ, 1, 0, 4'd8, 4'b1000, 0, 1, 2'b00, 2'b01, 0, 2'b00, 1, 0));
    tbl.push_back(fetch(BEQ));
    tbl.push_back(dec(BEQ));
    tbl.push_back(v(0, BEQ, 0, 0, 4'd8, 4'b0000, 0, 1, 2'b00, 2'b01, 0, 2'b00, 1, 0));
    tbl.push_back(fetch(JAL));
    tbl.push_back(v(0, JAL, 0, 0, 4'd1, 4'b0000, 0, 0, 2'b11, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(v(0, JAL, 0, 0, 4'd9, 4'b1001, 0, 0, 2'b00, 2'b00, 1, 2'b10, 1, 0));
    tbl.push_back(fetch(ADD0));
    tbl.push_back(dec(ADD0));
    tbl.push_back(v(0, ADD0, 0, 1, 4'd2, 4'b0000, 0, 1, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(v(1, ADD0, 0, 0, 4'd3, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(fetch(ADDC));
    tbl.push_back(dec(ADDC));
    tbl.push_back(fetch(ILL));
    tbl.push_back(v(1, ILL, 0, 0, 4'd1, 4'b0000, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0));
    tbl.push_back(fetch(ILL));
    tbl.push_back(v(0, ILL, 0, 0, 4'd1, 4'b0000, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 1));
    foreach (tbl[i]) step(tbl[i], "table");
`ifdef ILLEGAL_TRAP_EN
    step(v(0, ILL, 1, 1, 4'd10, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0), "halt_hold");
    step(v(0, ADD0, 1, 0, 4'd10, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0), "halt_hold");
    step(v(0, JAL, 0, 1, 4'd10, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0), "halt_hold");
    step(v(1, ADD0, 0, 0, 4'd10, 4'b0000, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0), "halt_reset");
`endif
    step(fetch(LD), "ld_reset");
    step(dec(LD), "ld_reset");
    step(v(0, LD, 0, 0, 4'd4, 4'b0000, 0, 1, 2'b10, 2'b00, 0, 2'b00, 0, 0), "ld_reset");
    step(v(0, LD, 0, 0, 4'd5, 4'b0000, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0), "ld_reset");
    step(v(1, LD, 0, 0, 4'd6, 4'b0000, 0, 0, 2'b00, 2'b00, 1, 2'b01, 0, 0), "ld_reset");
    step(fetch(LD), "post_reset_fetch");
    step(dec(LD), "post_reset_fetch");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
